// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {RESP_NONE, RESP_IF, RESP_D} resp_owner_t;

  localparam int MEM_WORDS = 2**12;

  // Byte to word address; the caller truncates to its port width, so high bits wrap.
  function automatic logic [31:0] byte_to_word(input logic [31:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/mem_arb_starve_guard.sv
// Counts consecutive denied fetch cycles and flags when fetch must win.
module mem_arb_starve_guard #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  output logic force_if
);

  logic [3:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (rst)                   starve_cnt <= '0;
    else if (!if_req || if_gnt) starve_cnt <= '0;
    else if (starve_cnt != 4'(STARVE_MAX))
      starve_cnt <= starve_cnt + 4'd1;
  end

  assign force_if = (starve_cnt == 4'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter for a single-port sync memory, data priority with fetch starvation guard.
// Optional grant/conflict counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_if_gnt,
  output logic [31:0]       stat_d_gnt,
  output logic [31:0]       stat_conflict
`endif
);

  logic        force_if;
  resp_owner_t resp;

  mem_arb_starve_guard #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_gnt   (if_gnt),
    .force_if (force_if)
  );

  assign if_gnt = !rst && if_req && (!d_req || force_if);
  assign d_gnt  = !rst && d_req  && !(if_req && force_if);

  assign m_en = if_gnt || d_gnt;
  assign m_we = d_gnt && d_we;

  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    if (if_gnt) begin
      m_addr = ADDR_W'(byte_to_word(if_addr));
    end else if (d_gnt) begin
      m_addr  = ADDR_W'(byte_to_word(d_addr));
      m_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                resp <= RESP_NONE;
    else if (if_gnt)        resp <= RESP_IF;
    else if (d_gnt && !d_we) resp <= RESP_D;
    else                    resp <= RESP_NONE;
  end

  // Gated by rst so a read in flight when reset hits never surfaces.
  assign if_rvalid = !rst && (resp == RESP_IF);
  assign d_rvalid  = !rst && (resp == RESP_D);
  assign if_rdata  = m_rdata;
  assign d_rdata   = m_rdata;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_if_gnt   <= '0;
      stat_d_gnt    <= '0;
      stat_conflict <= '0;
    end else begin
      if (if_gnt)          stat_if_gnt   <= stat_if_gnt + 32'd1;
      if (d_gnt)           stat_d_gnt    <= stat_d_gnt + 32'd1;
      if (if_req && d_req) stat_conflict <= stat_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic vs a behavioural model.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 12;
  localparam int STARVE_MAX = 3;
  localparam int DEPTH      = 4096;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [31:0]       if_addr = '0;
  logic              if_gnt, if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req = 1'b0, d_we = 1'b0;
  logic [31:0]       d_addr = '0, d_wdata = '0;
  logic              d_gnt, d_rvalid;
  logic [31:0]       d_rdata;
  logic              m_en, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [31:0]       stat_if_gnt, stat_d_gnt, stat_conflict;
`endif

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
`ifdef MEM_ARB_STATS_EN
    , .stat_if_gnt(stat_if_gnt), .stat_d_gnt(stat_d_gnt), .stat_conflict(stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Memory array the arbiter drives: synchronous read and write.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] = m_wdata;
      else      m_rdata <= mem[m_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: requester view of who wins and what data comes back.
  logic [31:0] ref_mem [DEPTH];
  bit          model_on = 1'b0;
  int          denied = 0;
  int          pend = 0;          // 0 nothing, 1 fetch read due, 2 load read due
  logic [31:0] pend_data = '0;

  always @(negedge clk) begin
    if (model_on) begin
      bit gi, gd;
      int wa;
      logic [31:0] ew;
      if (rst) begin
        chk("rst_idle", 64'({if_gnt, d_gnt, m_en, m_we, if_rvalid, d_rvalid}), 64'd0);
        denied = 0;
        pend   = 0;
      end else begin
        chk("rvalid", 64'({if_rvalid, d_rvalid}), 64'({pend == 1, pend == 2}));
        if (pend == 1) chk("if_rdata", 64'(if_rdata), 64'(pend_data));
        if (pend == 2) chk("d_rdata", 64'(d_rdata), 64'(pend_data));
        if (if_req && d_req) gi = (denied >= STARVE_MAX);
        else                 gi = if_req;
        gd = d_req && !gi;
        chk("grant", 64'({if_gnt, d_gnt, m_en, m_we}), 64'({gi, gd, gi || gd, gd && d_we}));
        wa = 0;
        ew = '0;
        if (gi)      wa = int'((if_addr >> 2) % 32'(DEPTH));
        else if (gd) begin
          wa = int'((d_addr >> 2) % 32'(DEPTH));
          ew = d_wdata;
        end
        chk("m_addr", 64'(m_addr), 64'(wa));
        chk("m_wdata", 64'(m_wdata), 64'(ew));
        pend = 0;
        if (gi) begin
          pend = 1; pend_data = ref_mem[wa];
        end else if (gd && !d_we) begin
          pend = 2; pend_data = ref_mem[wa];
        end else if (gd) begin
          ref_mem[wa] = d_wdata;
        end
        if (if_req && !gi) denied = (denied < STARVE_MAX) ? denied + 1 : denied;
        else               denied = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_C000);
    return a;
  endfunction

  initial begin
    bit gi_s, gd_s;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    model_on = 1'b1;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("reset_state", 64'({if_gnt, d_gnt, m_en, m_we, if_rvalid, d_rvalid}), 64'd0);
    step();
    rst = 1'b0;

    // Fetch only from 0x10 for three cycles
    for (int i = 0; i < 4; i++) begin
      if_req  = (i < 3);
      if_addr = 32'h10;
      @(negedge clk);
      if (i < 3) chk("fetch_gnt_addr", 64'({if_gnt, m_addr}), 64'({1'b1, 12'd4}));
      if (i > 0) chk("fetch_rdata", 64'({if_rvalid, if_rdata}), 64'({1'b1, init_word(4)}));
      step();
    end
    if_req = 1'b0;

    // Store then load to the same word
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("store_we", 64'({d_gnt, m_we, m_addr}), 64'({2'b11, 12'd16}));
    step();
    d_we = 1'b0;
    @(negedge clk);
    chk("load_after_store_no_rvalid", 64'({d_rvalid, m_we, d_gnt}), 64'({1'b0, 1'b0, 1'b1}));
    step();
    d_req = 1'b0;
    @(negedge clk);
    chk("load_new_data", 64'({d_rvalid, d_rdata}), 64'({1'b1, 32'hDEADBEEF}));

    // Address wrap
    step();
    d_req = 1'b1; d_addr = 32'h4000;
    @(negedge clk);
    chk("wrap_addr", 64'({d_gnt, m_addr}), 64'({1'b1, 12'd0}));
    step();
    d_req = 1'b0;

    // Reset while a fetch read is outstanding
    if_req = 1'b1; if_addr = 32'h20;
    @(negedge clk);
    chk("pre_rst_gnt", 64'(if_gnt), 64'd1);
    step();
    rst = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    @(negedge clk);
    chk("rst_mid_read", 64'({if_rvalid, if_gnt, d_gnt, m_en, m_we}), 64'd0);
    step();
    @(negedge clk);
    chk("rst_held_idle", 64'({if_gnt, d_gnt, m_en, d_rvalid}), 64'd0);
    step();
    rst = 1'b0;

    // Contention: D,D,D,I repeating
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("contention_pattern", 64'({if_gnt, d_gnt}), (i % 4 == 3) ? 64'd2 : 64'd1);
      step();
    end
    if_req = 1'b0; d_req = 1'b0;
`ifdef MEM_ARB_STATS_EN
    @(negedge clk);
    chk("stat_conflict", 64'(stat_conflict), 64'd8);
    chk("stat_d_gnt", 64'(stat_d_gnt), 64'd6);
    chk("stat_if_gnt", 64'(stat_if_gnt), 64'd2);
`endif
    step();

    // Randomized traffic with the hold-until-grant handshake
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      gi_s = if_gnt;
      gd_s = d_gnt;
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 199) == 0);
      if (!if_req || gi_s || $urandom_range(0, 15) == 0) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = rand_addr();
      end
      if (!d_req || gd_s || $urandom_range(0, 15) == 0) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = rand_addr();
        d_wdata = $urandom;
      end
    end
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
